// File: rtl/sram_1rw_arb_pkg.sv
// Shared constants and types for the two-port 1RW SRAM arbiter.
// Struct field widths follow the macro geometry fixed here.
package sram_1rw_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned SRAM_BITS = 512;
  localparam int unsigned SRAM_AW   = 12;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic                 we;
    logic [SRAM_AW-1:0]   addr;
    logic [SRAM_BITS-1:0] wd;
    logic [SRAM_BITS-1:0] mask;
    port_id_t             port;
  } s1_t;

endpackage

// File: rtl/sram_1rw_arb_if.sv
// Per-client request/response bundle; the client is master, the arbiter is slave.
interface sram_1rw_arb_if
  import sram_1rw_arb_pkg::*;
#(
  parameter int unsigned BITS       = SRAM_BITS,
  parameter int unsigned ADDR_WIDTH = SRAM_AW
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BITS-1:0]       req_wd;
  logic [BITS-1:0]       req_mask;
  logic                  rsp_valid;
  logic [BITS-1:0]       rsp_data;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wd, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wd, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sram_1rw_arb_rsp_fifo.sv
// Per-port read response FIFO; head entry is presented combinationally.
// Storage is not reset: data is only meaningful while valid is high.
module sram_1rw_arb_rsp_fifo #(
  parameter int unsigned BITS  = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic            valid,
  output logic [BITS-1:0] data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            full;

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  full_push_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("response FIFO push while full");

endmodule

// File: rtl/sram_1rw_arb.sv
// Round-robin arbiter and 2-stage sequencer sharing one 1RW SRAM macro between two
// clients; read data is captured the cycle after issue and queued per port.
module sram_1rw_arb
  import sram_1rw_arb_pkg::*;
#(
  parameter int unsigned BITS       = SRAM_BITS,
  parameter int unsigned ADDR_WIDTH = SRAM_AW,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_1rw_arb_if.slave         p0,
  sram_1rw_arb_if.slave         p1,
  output logic                  sram_ce_out,
  output logic                  sram_we_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_out,
  output logic [BITS-1:0]       sram_wd_out,
  output logic [BITS-1:0]       sram_mask_out,
  input  logic [BITS-1:0]       sram_rd_in
);

  localparam int unsigned   CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CREDITS = CW'(RSP_DEPTH);

  logic [NUM_PORTS-1:0] req_valid, req_we, elig, grant;
  logic [NUM_PORTS-1:0] push, pop, fifo_valid, rsp_ready;
  logic [BITS-1:0]      fifo_data0, fifo_data1;
  logic [CW-1:0]        out_q [NUM_PORTS];
  logic [CW-1:0]        out_d [NUM_PORTS];
  port_id_t             last_grant_q;
  logic                 ce_q;
  s1_t                  s1_q, s1_req;
  logic                 s2_valid_q;
  port_id_t             s2_port_q;

  assign req_valid = {p1.req_valid, p0.req_valid};
  assign req_we    = {p1.req_we, p0.req_we};
  assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};

  // A credit is held from read accept until the response is popped, so a pop in
  // the same cycle cannot free it for the current decision.
  always_comb begin
    for (int n = 0; n < NUM_PORTS; n++) begin
      elig[n] = req_valid[n] & (req_we[n] | (out_q[n] < CREDITS));
    end
    if (&elig) grant = last_grant_q[0] ? 2'b01 : 2'b10;
    else       grant = elig;
  end

  assign p0.req_ready = grant[0];
  assign p1.req_ready = grant[1];

  always_comb begin
    if (grant[1]) begin
      s1_req = '{we: p1.req_we, addr: p1.req_addr, wd: p1.req_wd, mask: p1.req_mask,
                 port: 1'b1};
    end else begin
      s1_req = '{we: p0.req_we, addr: p0.req_addr, wd: p0.req_wd, mask: p0.req_mask,
                 port: 1'b0};
    end
  end

  // Issue stage: payload fields hold when idle, only ce/we drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q         <= 1'b0;
      s1_q         <= '0;
      last_grant_q <= 1'b1;
    end else begin
      ce_q <= |grant;
      if (|grant) begin
        s1_q         <= s1_req;
        last_grant_q <= grant[1];
      end else begin
        s1_q.we <= 1'b0;
      end
    end
  end

  assign sram_ce_out   = ce_q;
  assign sram_we_out   = s1_q.we;
  assign sram_addr_out = s1_q.addr;
  assign sram_wd_out   = s1_q.wd;
  assign sram_mask_out = s1_q.mask;

  // Capture stage: marks the single cycle in which sram_rd_in carries read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_port_q  <= '0;
    end else begin
      s2_valid_q <= ce_q & ~s1_q.we;
      s2_port_q  <= s1_q.port;
    end
  end

  assign push = {s2_valid_q & s2_port_q[0], s2_valid_q & ~s2_port_q[0]};
  assign pop  = fifo_valid & rsp_ready;

  always_comb begin
    for (int n = 0; n < NUM_PORTS; n++) begin
      case ({grant[n] & ~req_we[n], pop[n]})
        2'b10:   out_d[n] = out_q[n] + 1'b1;
        2'b01:   out_d[n] = out_q[n] - 1'b1;
        default: out_d[n] = out_q[n];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_PORTS; n++) out_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_PORTS; n++) out_q[n] <= out_d[n];
    end
  end

  sram_1rw_arb_rsp_fifo #(
    .BITS  (BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[0]),
    .push_data (sram_rd_in),
    .pop       (pop[0]),
    .valid     (fifo_valid[0]),
    .data      (fifo_data0)
  );

  sram_1rw_arb_rsp_fifo #(
    .BITS  (BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[1]),
    .push_data (sram_rd_in),
    .pop       (pop[1]),
    .valid     (fifo_valid[1]),
    .data      (fifo_data1)
  );

  assign p0.rsp_valid = fifo_valid[0];
  assign p0.rsp_data  = fifo_data0;
  assign p1.rsp_valid = fifo_valid[1];
  assign p1.rsp_data  = fifo_data1;

endmodule
